// File: rtl/rs_gf_pkg.sv
// Shared GF(2^M) definitions for the Reed-Solomon decoder blocks
// (syndrome engine, Berlekamp-Massey, Chien search).
package rs_gf_pkg;

  // Default field: GF(2^8) generated by x^8 + x^4 + x^3 + x^2 + 1.
  localparam int         M         = 8;
  localparam logic [8:0] PRIM_POLY = 9'h11D;

  // Input side: waiting for a start-of-codeword, or accumulating one.
  typedef enum logic {
    IN_IDLE = 1'b0,
    IN_ACC  = 1'b1
  } in_state_t;

  // Output side: result bank empty, or draining syndromes downstream.
  typedef enum logic {
    OUT_EMPTY = 1'b0,
    OUT_SEND  = 1'b1
  } out_state_t;

  // Multiply by alpha (= x) with reduction by the field polynomial.
  function automatic logic [M-1:0] gf_xtime(input logic [M-1:0] a);
    gf_xtime = {a[M-2:0], 1'b0} ^ (a[M-1] ? PRIM_POLY[M-1:0] : '0);
  endfunction

  // alpha^e, exponent taken mod 2^M-1; intended for constant tables.
  function automatic logic [M-1:0] gf_alpha_pow(input int e);
    logic [M-1:0] r;
    int           em;
    r  = {{(M-1){1'b0}}, 1'b1};
    em = e % ((1 << M) - 1);
    for (int k = 0; k < em; k++) begin
      r = gf_xtime(r);
    end
    gf_alpha_pow = r;
  endfunction

  // General shift-and-add field multiply.
  function automatic logic [M-1:0] gf_mul(input logic [M-1:0] a, input logic [M-1:0] b);
    logic [M-1:0] p;
    logic [M-1:0] t;
    p = '0;
    t = a;
    for (int k = 0; k < M; k++) begin
      if (b[k]) p = p ^ t;
      t = gf_xtime(t);
    end
    gf_mul = p;
  endfunction

endpackage

// File: rtl/gf_const_mul.sv
// Combinational multiply of x by the constant alpha^EXP in GF(2^M).
// The constant is folded at elaboration, so the result is a pure XOR network.
module gf_const_mul #(
  parameter int         M         = 8,
  parameter logic [M:0] PRIM_POLY = 9'h11D,
  parameter int         EXP       = 1
) (
  input  logic [M-1:0] x,
  output logic [M-1:0] y
);

  function automatic logic [M-1:0] xtime(input logic [M-1:0] a);
    xtime = {a[M-2:0], 1'b0} ^ (a[M-1] ? PRIM_POLY[M-1:0] : '0);
  endfunction

  function automatic logic [M-1:0] alpha_pow(input int e);
    logic [M-1:0] r;
    int           em;
    r  = {{(M-1){1'b0}}, 1'b1};
    em = e % ((1 << M) - 1);
    for (int k = 0; k < em; k++) begin
      r = xtime(r);
    end
    alpha_pow = r;
  endfunction

  localparam logic [M-1:0] COEF = alpha_pow(EXP);

  logic [M-1:0] prod;
  logic [M-1:0] term;

  // Shift-and-add against the constant coefficient bits.
  always_comb begin
    prod = '0;
    term = x;
    for (int b = 0; b < M; b++) begin
      if (COEF[b]) prod = prod ^ term;
      term = xtime(term);
    end
    y = prod;
  end

endmodule

// File: rtl/rs_syndrome_engine.sv
// Reed-Solomon syndrome engine: evaluates S_j = r(alpha^j), j = FCR..FCR+NSYM-1,
// by Horner's rule, one received symbol per clock, highest-degree symbol first.
// Finished syndromes move to an output bank so the next codeword can accumulate
// while the previous set drains.
//
// Handshakes: a beat moves on an edge where valid and ready are both high; the
// sender holds valid and payload until then, and payload is held stable while
// valid is high and ready is low. in_ready depends on syn_ready only through the
// last-symbol stall (bank still full when the final symbol arrives).
module rs_syndrome_engine #(
  parameter int         M         = rs_gf_pkg::M,
  parameter int         NSYM      = 32,
  parameter int         N         = 255,
  parameter int         FCR       = 1,
  parameter logic [M:0] PRIM_POLY = rs_gf_pkg::PRIM_POLY,
  localparam int        LW        = $clog2(N + 1),
  localparam int        IW        = $clog2(NSYM)
) (
  input  logic          clock,
  input  logic          reset,        // asynchronous, active-low
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          in_sop,
  input  logic [M-1:0]  in_data,
  input  logic [LW-1:0] cw_len,
  output logic          syn_valid,
  input  logic          syn_ready,
  output logic [M-1:0]  syn_data,
  output logic [IW-1:0] syn_idx,
  output logic          syn_last,
  output logic          cw_ok,
  output logic          drop_pulse,
  output logic          abort_pulse,
  output logic [1:0]    fsm_state     // {output FSM, input FSM} for observation
);

  import rs_gf_pkg::*;

  in_state_t    in_state;
  in_state_t    in_next;
  out_state_t   out_state;
  out_state_t   out_next;

  logic [LW-1:0] cnt;
  logic [LW-1:0] len;
  logic [LW-1:0] eff_len;
  logic [IW-1:0] idx;
  logic          ok_r;
  logic          ready_en;

  logic [M-1:0]  acc      [0:NSYM-1];
  logic [M-1:0]  acc_mul  [0:NSYM-1];
  logic [M-1:0]  acc_next [0:NSYM-1];
  logic [M-1:0]  bank     [0:NSYM-1];
  logic          all_zero;

  logic at_last;
  logic out_full;
  logic stall;
  logic xfer;
  logic sop_xfer;
  logic acc_xfer;
  logic last_xfer;
  logic drain;
  logic fire_last;

  // Out-of-range lengths (too short to hold NSYM check symbols, or longer
  // than the field allows) fall back to the full code length.
  assign eff_len = ((int'(cw_len) < NSYM + 1) || (int'(cw_len) > N)) ? LW'(N) : cw_len;

  assign at_last   = (in_state == IN_ACC) && (cnt == len - LW'(1));
  assign out_full  = (out_state == OUT_SEND);
  assign stall     = at_last && out_full;
  assign in_ready  = ready_en && !stall;
  assign xfer      = in_valid && in_ready;
  assign sop_xfer  = xfer && in_sop;
  assign acc_xfer  = xfer && !in_sop && (in_state == IN_ACC);
  assign last_xfer = acc_xfer && at_last;

  assign syn_valid = out_full;
  assign syn_idx   = idx;
  assign syn_data  = bank[idx];
  assign syn_last  = out_full && (idx == IW'(NSYM - 1));
  assign cw_ok     = out_full && ok_r;
  assign drain     = syn_valid && syn_ready;
  assign fire_last = drain && syn_last;
  assign fsm_state = {out_state, in_state};

  // One constant multiplier per syndrome: acc[i] * alpha^(FCR+i).
  for (genvar i = 0; i < NSYM; i++) begin : g_mul
    gf_const_mul #(
      .M         (M),
      .PRIM_POLY (PRIM_POLY),
      .EXP       (FCR + i)
    ) u_mul (
      .x (acc[i]),
      .y (acc_mul[i])
    );
  end

  // Horner step; a start-of-codeword symbol reseeds every accumulator.
  always_comb begin
    for (int i = 0; i < NSYM; i++) begin
      acc_next[i] = in_sop ? in_data : (acc_mul[i] ^ in_data);
    end
  end

  // No-error flag: every finished syndrome is zero.
  always_comb begin
    all_zero = 1'b1;
    for (int i = 0; i < NSYM; i++) begin
      if (acc_next[i] != '0) all_zero = 1'b0;
    end
  end

  // Input FSM next state; a mid-codeword sop restarts but stays in ACC.
  always_comb begin
    in_next = in_state;
    case (in_state)
      IN_IDLE: if (sop_xfer)  in_next = IN_ACC;
      IN_ACC:  if (last_xfer) in_next = IN_IDLE;
      default: in_next = IN_IDLE;
    endcase
  end

  // Output FSM next state; a load only happens while the bank is empty.
  always_comb begin
    out_next = out_state;
    case (out_state)
      OUT_EMPTY: if (last_xfer) out_next = OUT_SEND;
      OUT_SEND:  if (fire_last) out_next = OUT_EMPTY;
      default:   out_next = OUT_EMPTY;
    endcase
  end

  // State registers for both FSMs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      in_state  <= IN_IDLE;
      out_state <= OUT_EMPTY;
    end else begin
      in_state  <= in_next;
      out_state <= out_next;
    end
  end

  // Keeps in_ready low while in reset and rising one edge after release.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) ready_en <= 1'b0;
    else        ready_en <= 1'b1;
  end

  // Symbol counter and latched codeword length.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
      len <= '0;
    end else if (sop_xfer) begin
      cnt <= LW'(1);
      len <= eff_len;
    end else if (acc_xfer) begin
      cnt <= cnt + LW'(1);
    end
  end

  // Syndrome accumulators advance on every accepted in-codeword symbol.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NSYM; i++) acc[i] <= '0;
    end else if (sop_xfer || acc_xfer) begin
      for (int i = 0; i < NSYM; i++) acc[i] <= acc_next[i];
    end
  end

  // Output bank captures the final syndromes on the last-symbol transfer.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NSYM; i++) bank[i] <= '0;
      ok_r <= 1'b0;
    end else if (last_xfer) begin
      for (int i = 0; i < NSYM; i++) bank[i] <= acc_next[i];
      ok_r <= all_zero;
    end
  end

  // Drain index walks the bank one handshake at a time.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      idx <= '0;
    end else if (last_xfer) begin
      idx <= '0;
    end else if (drain) begin
      idx <= syn_last ? '0 : idx + IW'(1);
    end
  end

  // Single-cycle event flags for discarded or restarted input.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      drop_pulse  <= 1'b0;
      abort_pulse <= 1'b0;
    end else begin
      drop_pulse  <= xfer && !in_sop && (in_state == IN_IDLE);
      abort_pulse <= sop_xfer && (in_state == IN_ACC);
    end
  end

endmodule
